// File: rtl/sine_freq_meter.sv
// -----------------------------------------------------------------------------
// sine_freq_meter
//   Monitor-path frequency meter for the DDS sine source. Counts rising
//   mid-scale crossings (with hysteresis) of an unsigned 10-bit sine stream
//   over a gate window of 2^GATE_LOG2 clocks and converts the count into an
//   estimated frequency control word. The min/max amplitude seen in the
//   window is reported alongside.
//
// Ports
//   clk        in   sample clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = run gate windows back to back, 0 = idle
//   data_sin   in   [9:0] unsigned sine sample, one per clock
//   fcw_est    out  [7:0] estimated FCW from the last completed window
//   amp_max    out  [9:0] largest sample in the last completed window
//   amp_min    out  [9:0] smallest sample in the last completed window
//   meas_valid out  one-cycle pulse while the outputs carry a fresh result
//   signal_ok  out  last completed window saw at least 2 rising crossings
// -----------------------------------------------------------------------------
module sine_freq_meter #(
   parameter int GATE_LOG2 = 14,   // legal range 11..20
   parameter int MID       = 512,
   parameter int HYST      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [9:0] data_sin,
   output logic [7:0] fcw_est,
   output logic [9:0] amp_max,
   output logic [9:0] amp_min,
   output logic       meas_valid,
   output logic       signal_ok
);

   localparam int CW = GATE_LOG2 - 2;   // crossing counter width

   localparam logic [9:0] TH_HI = 10'(MID + HYST);
   localparam logic [9:0] TH_LO = 10'(MID - HYST);
   localparam logic [9:0] TH_MID = 10'(MID);

   // Half an LSB of the final shift, for round-half-up.
   localparam logic [CW:0] RND = (CW+1)'(1) << (GATE_LOG2 - 11);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      GATE,
      REPORT
   } state_t;

   state_t                 state_q, state_d;
   logic [GATE_LOG2-1:0]   gate_cnt_q, gate_cnt_d;
   logic [CW-1:0]          cross_cnt_q, cross_cnt_d;
   logic                   hyst_q, hyst_d;        // 1 = HIGH, 0 = LOW
   logic [9:0]             run_max_q, run_max_d;
   logic [9:0]             run_min_q, run_min_d;
   logic [7:0]             fcw_est_q, fcw_est_d;
   logic [9:0]             amp_max_q, amp_max_d;
   logic [9:0]             amp_min_q, amp_min_d;
   logic                   signal_ok_q, signal_ok_d;

   logic [CW:0]            fcw_sum;
   logic [CW:0]            fcw_shift;

   // ------------------------------------------------------------------------
   // Next-state / datapath
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case statement leaves one unassigned, which would infer a latch.
      state_d     = state_q;
      gate_cnt_d  = gate_cnt_q;
      cross_cnt_d = cross_cnt_q;
      hyst_d      = hyst_q;
      run_max_d   = run_max_q;
      run_min_d   = run_min_q;
      fcw_est_d   = fcw_est_q;
      amp_max_d   = amp_max_q;
      amp_min_d   = amp_min_q;
      signal_ok_d = signal_ok_q;
      fcw_sum     = '0;
      fcw_shift   = '0;

      unique case (state_q)
         IDLE: begin
            if (enable) state_d = ARM;
         end

         ARM: begin
            gate_cnt_d  = '0;
            cross_cnt_d = '0;
            run_max_d   = '0;
            run_min_d   = '1;
            // Seed the detector from the current level so a window that
            // starts above mid-scale does not count a spurious crossing.
            hyst_d      = (data_sin >= TH_MID);
            state_d     = GATE;
         end

         GATE: begin
            if (!enable) begin
               // Abort: results of the partial window are discarded.
               state_d = IDLE;
            end else begin
               gate_cnt_d = gate_cnt_q + 1'b1;

               if (!hyst_q && (data_sin >= TH_HI)) begin
                  hyst_d = 1'b1;
                  if (cross_cnt_q != '1) cross_cnt_d = cross_cnt_q + 1'b1;
               end else if (hyst_q && (data_sin <= TH_LO)) begin
                  hyst_d = 1'b0;
               end

               if (data_sin > run_max_q) run_max_d = data_sin;
               if (data_sin < run_min_q) run_min_d = data_sin;

               // Final gate sample: capture results from the updated values
               // so they are visible during the REPORT cycle itself.
               if (gate_cnt_q == '1) begin
                  state_d     = REPORT;
                  fcw_sum     = {1'b0, cross_cnt_d} + RND;
                  fcw_shift   = fcw_sum >> (GATE_LOG2 - 10);
                  fcw_est_d   = (fcw_shift > (CW+1)'(255)) ? 8'hFF : fcw_shift[7:0];
                  amp_max_d   = run_max_d;
                  amp_min_d   = run_min_d;
                  signal_ok_d = (cross_cnt_d >= CW'(2));
               end
            end
         end

         REPORT: begin
            state_d = enable ? ARM : IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gate_cnt_q  <= '0;
         cross_cnt_q <= '0;
         hyst_q      <= 1'b0;
         run_max_q   <= '0;
         run_min_q   <= '1;
         fcw_est_q   <= '0;
         amp_max_q   <= '0;
         amp_min_q   <= 10'h3FF;
         signal_ok_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gate_cnt_q  <= gate_cnt_d;
         cross_cnt_q <= cross_cnt_d;
         hyst_q      <= hyst_d;
         run_max_q   <= run_max_d;
         run_min_q   <= run_min_d;
         fcw_est_q   <= fcw_est_d;
         amp_max_q   <= amp_max_d;
         amp_min_q   <= amp_min_d;
         signal_ok_q <= signal_ok_d;
      end
   end

   assign fcw_est    = fcw_est_q;
   assign amp_max    = amp_max_q;
   assign amp_min    = amp_min_q;
   assign signal_ok  = signal_ok_q;
   assign meas_valid = (state_q == REPORT);

endmodule

// File: tb/tb_sine_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_sine_freq_meter
//   Directed bench for sine_freq_meter, built with GATE_LOG2=11 (2048-clock
//   gate, 2050-clock window) to keep run time short. At this setting
//   crossings = 2*fcw, fcw_est = (crossings + 1) >> 1, and the crossing
//   counter is 9 bits (saturates at 511).
// -----------------------------------------------------------------------------
module tb_sine_freq_meter;

   localparam int GL     = 11;
   localparam int WINDOW = (1 << GL) + 2;
   localparam int LIMIT  = WINDOW + 500;

   typedef enum int { M_SINE, M_SQUARE, M_ALT, M_PULSE } mode_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [9:0] data_sin;
   logic [7:0] fcw_est;
   logic [9:0] amp_max;
   logic [9:0] amp_min;
   logic       meas_valid;
   logic       signal_ok;

   int errors = 0;
   int checks = 0;

   mode_t      mode;
   int         tick;
   logic [9:0] phase;
   logic [9:0] fcw;
   logic [9:0] alt_a, alt_b;
   int         pulses;
   int         cyc;
   int         seen;

   sine_freq_meter #(.GATE_LOG2(GL), .MID(512), .HYST(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .data_sin   (data_sin),
      .fcw_est    (fcw_est),
      .amp_max    (amp_max),
      .amp_min    (amp_min),
      .meas_valid (meas_valid),
      .signal_ok  (signal_ok)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Present the sample for the next clock edge.
   task automatic drive();
      case (mode)
         M_SINE:   data_sin = 10'(512 + int'(511.0 * $sin(2.0 * 3.14159265358979 * real'(phase) / 1024.0)));
         M_SQUARE: data_sin = ((tick % 16) < 8) ? 10'd100 : 10'd900;
         M_ALT:    data_sin = tick[0] ? alt_b : alt_a;
         default:  data_sin = ((tick >= 500 && tick < 510) ||
                               (pulses == 2 && tick >= 1000 && tick < 1010)) ? 10'd900 : 10'd100;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      tick++;
      phase = phase + fcw;
      drive();
   endtask

   // Count clocks until meas_valid is seen; LIMIT+1 reports a timeout.
   task automatic wait_valid(output int n);
      n = LIMIT + 1;
      for (int i = 1; i <= LIMIT; i++) begin
         step();
         if (meas_valid) begin
            n = i;
            break;
         end
      end
   endtask

   // Return to IDLE, load a new pattern, then raise enable.
   task automatic start(input mode_t m);
      enable = 1'b0;
      repeat (3) step();
      mode  = m;
      tick  = 0;
      phase = '0;
      drive();
      enable = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      mode     = M_SINE;
      fcw      = '0;
      tick     = 0;
      phase    = '0;
      alt_a    = '0;
      alt_b    = '0;
      pulses   = 0;
      data_sin = 10'd512;
      repeat (3) @(posedge clk);
      #1;
      check("rst_fcw", fcw_est, 0);
      check("rst_max", amp_max, 0);
      check("rst_min", amp_min, 1023);
      check("rst_valid", meas_valid, 0);
      check("rst_ok", signal_ok, 0);
      rst_n = 1'b1;

      // Sine fcw=16: 32 periods per gate.
      fcw = 10'd16;
      start(M_SINE);
      wait_valid(cyc);
      check("sine16_latency", cyc, WINDOW);
      check("sine16_fcw", fcw_est, 16);
      check("sine16_ok", signal_ok, 1);
      check("sine16_max", amp_max, 1023);
      check("sine16_min", amp_min, 1);
      step();
      check("valid_width", meas_valid, 0);
      wait_valid(cyc);
      check("period", cyc, WINDOW - 1);   // one clock already consumed above
      check("sine16_fcw2", fcw_est, 16);

      fcw = 10'd1;
      start(M_SINE);
      wait_valid(cyc);
      check("sine1_fcw", fcw_est, 1);

      fcw = 10'd255;
      start(M_SINE);
      wait_valid(cyc);
      check("sine255_fcw", fcw_est, 255);
      check("sine255_ok", signal_ok, 1);

      fcw = 10'd0;      // constant mid-scale sample
      start(M_SINE);
      wait_valid(cyc);
      check("const_fcw", fcw_est, 0);
      check("const_ok", signal_ok, 0);
      check("const_max", amp_max, 512);
      check("const_min", amp_min, 512);

      fcw = 10'd0;
      start(M_SQUARE);  // 128 crossings
      wait_valid(cyc);
      check("square_fcw", fcw_est, 64);
      check("square_max", amp_max, 900);
      check("square_min", amp_min, 100);
      check("square_ok", signal_ok, 1);

      alt_a = 10'd520; alt_b = 10'd504;
      start(M_ALT);
      wait_valid(cyc);
      check("hyst_in_fcw", fcw_est, 0);
      check("hyst_in_ok", signal_ok, 0);

      alt_a = 10'd527; alt_b = 10'd497;   // one LSB inside each threshold
      start(M_ALT);
      wait_valid(cyc);
      check("hyst_edge_in_fcw", fcw_est, 0);

      alt_a = 10'd528; alt_b = 10'd496;   // exactly on thresholds: ~1024 crossings
      start(M_ALT);
      wait_valid(cyc);
      check("sat_fcw", fcw_est, 255);
      check("sat_ok", signal_ok, 1);
      check("sat_max", amp_max, 528);
      check("sat_min", amp_min, 496);

      pulses = 1;
      start(M_PULSE);
      wait_valid(cyc);
      check("one_cross_fcw", fcw_est, 1);
      check("one_cross_ok", signal_ok, 0);

      pulses = 2;
      start(M_PULSE);
      wait_valid(cyc);
      check("two_cross_fcw", fcw_est, 1);
      check("two_cross_ok", signal_ok, 1);

      // Abort halfway through GATE: nothing updates, no pulse.
      alt_a = 10'd528; alt_b = 10'd496;
      start(M_ALT);
      seen = 0;
      repeat (1000) begin
         step();
         if (meas_valid) seen++;
      end
      enable = 1'b0;
      repeat (20) begin
         step();
         if (meas_valid) seen++;
      end
      check("abort_no_valid", seen, 0);
      check("abort_fcw_held", fcw_est, 1);
      check("abort_max_held", amp_max, 900);
      check("abort_min_held", amp_min, 100);
      mode  = M_SQUARE;
      tick  = 0;
      drive();
      enable = 1'b1;
      wait_valid(cyc);
      check("reenable_latency", cyc, WINDOW);
      check("reenable_fcw", fcw_est, 64);

      // Asynchronous reset mid-GATE.
      fcw = 10'd16;
      start(M_SINE);
      repeat (500) step();
      rst_n = 1'b0;
      #2;
      check("midrst_fcw", fcw_est, 0);
      check("midrst_max", amp_max, 0);
      check("midrst_min", amp_min, 1023);
      check("midrst_valid", meas_valid, 0);
      check("midrst_ok", signal_ok, 0);
      repeat (3) step();
      rst_n = 1'b1;
      wait_valid(cyc);
      check("postrst_latency", cyc, WINDOW);
      check("postrst_fcw", fcw_est, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
